// File: rtl/riscv_pkg.sv
// Shared decode definitions for the RV64 ID stage: opcodes, ALU op encoding,
// the packed control bundle and the opcode-to-control decoder.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,  // load/store address add
    ALU_SUB   = 2'b01,  // branch compare
    ALU_FUNCT = 2'b10   // decoded from funct3/funct7 in EX
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    logic    alu_src;
    alu_op_e alu_op;
    logic    illegal;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_R: begin
        c.reg_write = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      OP_IMM: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      OP_LOAD: begin
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
        c.alu_op     = ALU_ADD;
      end
      OP_STORE: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_BRANCH: begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  // Only these formats read rs2; I-type rs2 bits are immediate bits.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: selects the I/S/B immediate by opcode
// and sign-extends it to XLEN. R-type and unknown opcodes yield zero.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm
);

  logic w_unused_bits;
  assign w_unused_bits = ^i_instr[19:12];

  // Format select on opcode
  always_comb begin
    o_imm = '0;
    case (i_instr[6:0])
      OP_IMM, OP_LOAD:
        o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
      OP_STORE:
        o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OP_BRANCH:
        o_imm = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                 i_instr[30:25], i_instr[11:8], 1'b0};
      default:
        o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV64 ID stage: decodes the fetched instruction, reads operands with
// writeback bypass, detects load-use hazards and holds the ID/EX register.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [31:0]      in_instr,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [XLEN-1:0]  rf_rdata1,
  input  logic [XLEN-1:0]  rf_rdata2,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_rs1_val,
  output logic [XLEN-1:0]  out_rs2_val,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_mem_to_reg,
  output logic             out_branch,
  output logic             out_alu_src,
  output logic             out_illegal,
  output logic [1:0]       out_alu_op,
  output logic [CNT_W-1:0] stall_count
);

  logic [6:0]      w_opcode;
  ctrl_t           w_ctrl;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_hazard;
  logic            w_advance;

  logic             r_valid;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_rs1_val;
  logic [XLEN-1:0]  r_rs2_val;
  logic [XLEN-1:0]  r_imm;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [4:0]       r_rd;
  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_opcode = in_instr[6:0];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  assign w_ctrl   = decode_ctrl(w_opcode);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr (in_instr),
    .o_imm   (w_imm)
  );

  // Operand select: x0 reads zero, same-cycle writeback wins over the RF
  always_comb begin
    w_rs1_val = rf_rdata1;
    if (rs1_addr == '0)
      w_rs1_val = '0;
    else if (wb_reg_write && (wb_rd == rs1_addr))
      w_rs1_val = wb_data;

    w_rs2_val = rf_rdata2;
    if (rs2_addr == '0)
      w_rs2_val = '0;
    else if (wb_reg_write && (wb_rd == rs2_addr))
      w_rs2_val = wb_data;
  end

  assign w_hazard  = in_valid & r_valid & r_ctrl.mem_read & (r_rd != '0) &
                     ((r_rd == rs1_addr) | ((r_rd == rs2_addr) & uses_rs2(w_opcode)));
  assign w_advance = ~r_valid | out_ready;
  assign in_ready  = (w_advance & ~w_hazard) | flush;

  // ID/EX register: flush > bubble > capture > drain > hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1_val   <= '0;
      r_rs2_val   <= '0;
      r_imm       <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_ctrl      <= '0;
      r_stall_cnt <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_advance) begin
      if (w_hazard) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
        if (r_stall_cnt != '1)
          r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end else if (in_valid) begin
        r_valid   <= 1'b1;
        r_pc      <= in_pc;
        r_rs1_val <= w_rs1_val;
        r_rs2_val <= w_rs2_val;
        r_imm     <= w_imm;
        r_rs1     <= rs1_addr;
        r_rs2     <= rs2_addr;
        r_rd      <= in_instr[11:7];
        r_ctrl    <= w_ctrl;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid      = r_valid;
  assign out_pc         = r_pc;
  assign out_rs1_val    = r_rs1_val;
  assign out_rs2_val    = r_rs2_val;
  assign out_imm        = r_imm;
  assign out_rs1        = r_rs1;
  assign out_rs2        = r_rs2;
  assign out_rd         = r_rd;
  assign out_reg_write  = r_ctrl.reg_write;
  assign out_mem_read   = r_ctrl.mem_read;
  assign out_mem_write  = r_ctrl.mem_write;
  assign out_mem_to_reg = r_ctrl.mem_to_reg;
  assign out_branch     = r_ctrl.branch;
  assign out_alu_src    = r_ctrl.alu_src;
  assign out_illegal    = r_ctrl.illegal;
  assign out_alu_op     = r_ctrl.alu_op;
  assign stall_count    = r_stall_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_decode_stage;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 32;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [31:0]      in_instr;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [XLEN-1:0]  rf_rdata1;
  logic [XLEN-1:0]  rf_rdata2;
  logic             wb_reg_write;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_rs1_val;
  logic [XLEN-1:0]  out_rs2_val;
  logic [XLEN-1:0]  out_imm;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [4:0]       out_rd;
  logic             out_reg_write;
  logic             out_mem_read;
  logic             out_mem_write;
  logic             out_mem_to_reg;
  logic             out_branch;
  logic             out_alu_src;
  logic             out_illegal;
  logic [1:0]       out_alu_op;
  logic [CNT_W-1:0] stall_count;

  logic [8:0] ctrl_obs;
  assign ctrl_obs = {out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
                     out_branch, out_alu_src, out_alu_op, out_illegal};

  int unsigned n_pass;
  int unsigned n_total;

  decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_mem_to_reg(out_mem_to_reg), .out_branch(out_branch), .out_alu_src(out_alu_src),
    .out_illegal(out_illegal), .out_alu_op(out_alu_op),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference decode: control per opcode, immediate by plain signed arithmetic
  typedef struct {
    logic [63:0] imm;
    bit rw, mr, mw, m2r, br, asrc, ill;
    bit [1:0] aop;
  } dec_t;

  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t d;
    longint v;
    d = '{default: 0};
    v = 0;
    case (ins[6:0])
      7'h33: begin d.rw = 1; d.aop = 2; end
      7'h13: begin
        d.rw = 1; d.asrc = 1; d.aop = 2;
        v = longint'(ins[31:20]); if (v >= 2048) v -= 4096;
      end
      7'h03: begin
        d.rw = 1; d.mr = 1; d.m2r = 1; d.asrc = 1; d.aop = 0;
        v = longint'(ins[31:20]); if (v >= 2048) v -= 4096;
      end
      7'h23: begin
        d.mw = 1; d.asrc = 1; d.aop = 0;
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]); if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        d.br = 1; d.aop = 1;
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
            longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      default: d.ill = 1;
    endcase
    d.imm = v;
    return d;
  endfunction

  function automatic logic [8:0] ctrl_vec(input dec_t d);
    return {d.rw, d.mr, d.mw, d.m2r, d.br, d.asrc, d.aop, d.ill};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
  endfunction

  function automatic logic [63:0] ref_opnd(input logic [4:0] idx, input logic [63:0] rf,
                                           input bit wbw, input logic [4:0] wrd,
                                           input logic [63:0] wd);
    if (idx == 0) return 64'd0;
    if (wbw && wrd == idx) return wd;
    return rf;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 6))
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2, 3: w[6:0] = 7'h03;
      4: w[6:0] = 7'h23;
      5: w[6:0] = 7'h63;
      default: w[6:0] = ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h7F;
    endcase
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    w[11:7]  = 5'($urandom_range(0, 3));
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid = 0; in_pc = '0; in_instr = '0;
    rf_rdata1 = '0; rf_rdata2 = '0;
    wb_reg_write = 0; wb_rd = '0; wb_data = '0;
    flush = 0; out_ready = 1;
  endtask

  task automatic do_reset();
    reset = 0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", out_valid);
    else n_pass++;
    n_total++;
    if (stall_count !== '0) $display("FAIL reset_stall got=%0d exp=0", stall_count);
    else n_pass++;
    n_total++;
    if ({out_pc, out_rs1_val, out_rs2_val, out_imm} !== '0)
      $display("FAIL reset_payload got=%h/%h/%h/%h exp=0", out_pc, out_rs1_val, out_rs2_val, out_imm);
    else n_pass++;
    n_total++;
    if ({ctrl_obs, out_rs1, out_rs2, out_rd} !== '0)
      $display("FAIL reset_ctrl got=%h exp=0", {ctrl_obs, out_rs1, out_rs2, out_rd});
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
    else n_pass++;
  endtask

  task automatic test_addi();
    do_reset();
    in_valid = 1; in_pc = 64'h1000; in_instr = 32'h00700293;
    tick();
    in_valid = 0;
    n_total++;
    if (out_valid !== 1'b1 || out_imm !== 64'd7 || out_rd !== 5'd5 || out_pc !== 64'h1000)
      $display("FAIL addi_payload got v=%0b imm=%h rd=%0d pc=%h exp v=1 imm=7 rd=5 pc=1000",
               out_valid, out_imm, out_rd, out_pc);
    else n_pass++;
    n_total++;
    if (ctrl_obs !== 9'b1_0_0_0_0_1_10_0) $display("FAIL addi_ctrl got=%b exp=%b", ctrl_obs, 9'b100001100);
    else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    in_valid = 1; in_pc = 64'h100; in_instr = 32'h00813083;  // ld x1,8(x2)
    tick();
    in_pc = 64'h104; in_instr = 32'h004081B3;                  // add x3,x1,x4
    #1;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL loaduse_in_ready got=%0b exp=0", in_ready);
    else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b0 || stall_count !== 32'd1)
      $display("FAIL loaduse_bubble got v=%0b stall=%0d exp v=0 stall=1", out_valid, stall_count);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL loaduse_release got=%0b exp=1", in_ready);
    else n_pass++;
    tick();
    in_valid = 0;
    n_total++;
    if (out_valid !== 1'b1 || out_rs1 !== 5'd1 || out_rs2 !== 5'd4 || out_rd !== 5'd3 ||
        out_pc !== 64'h104 || ctrl_obs !== 9'b100000100)
      $display("FAIL loaduse_add got v=%0b rs1=%0d rs2=%0d rd=%0d pc=%h ctrl=%b exp v=1 rs1=1 rs2=4 rd=3 pc=104 ctrl=100000100",
               out_valid, out_rs1, out_rs2, out_rd, out_pc, ctrl_obs);
    else n_pass++;
    tick();
    n_total++;
    if (stall_count !== 32'd1) $display("FAIL loaduse_count_hold got=%0d exp=1", stall_count);
    else n_pass++;
  endtask

  task automatic test_bypass();
    do_reset();
    in_valid = 1; in_instr = 32'h00313823;  // sd x3,16(x2)
    rf_rdata1 = 64'd0; rf_rdata2 = 64'hAAAA_5555;
    wb_reg_write = 1; wb_rd = 5'd2; wb_data = 64'h1234;
    tick();
    drive_idle();
    n_total++;
    if (out_rs1_val !== 64'h1234 || out_rs2_val !== 64'hAAAA_5555 || out_imm !== 64'd16)
      $display("FAIL bypass_vals got rs1v=%h rs2v=%h imm=%h exp 1234/aaaa5555/10",
               out_rs1_val, out_rs2_val, out_imm);
    else n_pass++;
    n_total++;
    if (ctrl_obs !== 9'b0_0_1_0_0_1_00_0) $display("FAIL bypass_ctrl got=%b exp=001001000", ctrl_obs);
    else n_pass++;
  endtask

  task automatic test_branch();
    do_reset();
    in_valid = 1; in_instr = 32'hFE208EE3;  // beq x1,x2,-4
    tick();
    in_valid = 0;
    n_total++;
    if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL branch_imm got=%h exp=fffffffffffffffc", out_imm);
    else n_pass++;
    n_total++;
    if (ctrl_obs !== 9'b0_0_0_0_1_0_01_0 || out_rs1 !== 5'd1 || out_rs2 !== 5'd2)
      $display("FAIL branch_ctrl got=%b rs1=%0d rs2=%0d exp=000010010 rs1=1 rs2=2", ctrl_obs, out_rs1, out_rs2);
    else n_pass++;
  endtask

  task automatic test_backpressure_flush();
    do_reset();
    in_valid = 1; in_pc = 64'h1000; in_instr = 32'h00700293;
    tick();
    out_ready = 0; in_pc = 64'h2000; in_instr = 32'h00A00313;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL hold_in_ready[%0d] got=%0b exp=0", i, in_ready);
      else n_pass++;
      tick();
      n_total++;
      if (out_valid !== 1'b1 || out_pc !== 64'h1000 || out_imm !== 64'd7 || out_rd !== 5'd5)
        $display("FAIL hold_payload[%0d] got v=%0b pc=%h imm=%h rd=%0d exp v=1 pc=1000 imm=7 rd=5",
                 i, out_valid, out_pc, out_imm, out_rd);
      else n_pass++;
    end
    flush = 1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL flush_in_ready got=%0b exp=1", in_ready);
    else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL flush_valid got=%0b exp=0", out_valid);
    else n_pass++;
    flush = 0; in_valid = 0; out_ready = 1;
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL flush_dropped got=%0b exp=0", out_valid);
    else n_pass++;
  endtask

  task automatic test_illegal();
    do_reset();
    in_valid = 1; in_instr = 32'h0000007F;
    tick();
    in_valid = 0;
    n_total++;
    if (out_valid !== 1'b1 || ctrl_obs !== 9'b0_0_0_0_0_0_00_1)
      $display("FAIL illegal got v=%0b ctrl=%b exp v=1 ctrl=000000001", out_valid, ctrl_obs);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1; in_instr = 32'h00813083;  // ld x1,8(x2)
    tick();
    out_ready = 0; in_instr = 32'h004081B3; // add x3,x1,x4: hazard while EX stalled
    repeat (2) tick();
    n_total++;
    if (stall_count !== '0 || out_mem_read !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL stalled_hazard got stall=%0d mr=%0b v=%0b exp stall=0 mr=1 v=1",
               stall_count, out_mem_read, out_valid);
    else n_pass++;
    out_ready = 1;
    tick();  // bubble
    tick();  // add captured
    in_valid = 0; out_ready = 0;
    n_total++;
    if (out_valid !== 1'b1 || stall_count !== 32'd1)
      $display("FAIL pre_areset got v=%0b stall=%0d exp v=1 stall=1", out_valid, stall_count);
    else n_pass++;
    #2 reset = 0;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || stall_count !== '0)
      $display("FAIL async_reset got v=%0b stall=%0d exp v=0 stall=0", out_valid, stall_count);
    else n_pass++;
    drive_idle();
    tick();
    reset = 1;
  endtask

  task automatic test_random(input int unsigned cycles);
    bit               mv;
    logic [63:0]      mpc, mv1, mv2;
    logic [4:0]       mr1, mr2, mrd;
    dec_t             md, d;
    longint unsigned  mstall;
    logic [31:0]      ins;
    bit               hz, adv;
    do_reset();
    mv = 0; mstall = 0; md = '{default: 0};
    mpc = '0; mv1 = '0; mv2 = '0; mr1 = '0; mr2 = '0; mrd = '0;
    for (int unsigned c = 0; c < cycles; c++) begin
      n_total++;
      if (out_valid !== mv) $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, out_valid, mv);
      else n_pass++;
      n_total++;
      if (stall_count !== mstall[31:0]) $display("FAIL rnd_stall c=%0d got=%0d exp=%0d", c, stall_count, mstall);
      else n_pass++;
      if (mv) begin
        n_total++;
        if (out_pc !== mpc || out_rs1_val !== mv1 || out_rs2_val !== mv2)
          $display("FAIL rnd_payload c=%0d got %h/%h/%h exp %h/%h/%h", c,
                   out_pc, out_rs1_val, out_rs2_val, mpc, mv1, mv2);
        else n_pass++;
        n_total++;
        if ({out_rs1, out_rs2, out_rd, ctrl_obs} !== {mr1, mr2, mrd, ctrl_vec(md)})
          $display("FAIL rnd_ctrl c=%0d got %0d/%0d/%0d/%b exp %0d/%0d/%0d/%b", c,
                   out_rs1, out_rs2, out_rd, ctrl_obs, mr1, mr2, mrd, ctrl_vec(md));
        else n_pass++;
        if (!md.ill) begin
          n_total++;
          if (out_imm !== md.imm) $display("FAIL rnd_imm c=%0d got=%h exp=%h", c, out_imm, md.imm);
          else n_pass++;
        end
      end
      ins = rand_instr();
      in_instr     = ins;
      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 11) == 0);
      in_pc        = {32'($urandom), 32'($urandom)};
      rf_rdata1    = {32'($urandom), 32'($urandom)};
      rf_rdata2    = {32'($urandom), 32'($urandom)};
      wb_reg_write = ($urandom_range(0, 1) != 0);
      wb_rd        = 5'($urandom_range(0, 3));
      wb_data      = {32'($urandom), 32'($urandom)};
      #1;
      d   = ref_decode(ins);
      hz  = in_valid && mv && md.mr && (mrd != 0) &&
            ((mrd == ins[19:15]) || ((mrd == ins[24:20]) && reads_rs2(ins[6:0])));
      adv = !mv || out_ready;
      n_total++;
      if (in_ready !== ((adv && !hz) || flush))
        $display("FAIL rnd_in_ready c=%0d got=%0b exp=%0b", c, in_ready, (adv && !hz) || flush);
      else n_pass++;
      n_total++;
      if ({rs1_addr, rs2_addr} !== {ins[19:15], ins[24:20]})
        $display("FAIL rnd_rs_addr c=%0d got=%0d/%0d exp=%0d/%0d", c, rs1_addr, rs2_addr, ins[19:15], ins[24:20]);
      else n_pass++;
      if (flush) mv = 0;
      else if (adv) begin
        if (hz) begin
          mv = 0;
          md = '{default: 0};
          if (mstall < 64'hFFFF_FFFF) mstall++;
        end else if (in_valid) begin
          mv  = 1;
          mpc = in_pc;
          mv1 = ref_opnd(ins[19:15], rf_rdata1, wb_reg_write, wb_rd, wb_data);
          mv2 = ref_opnd(ins[24:20], rf_rdata2, wb_reg_write, wb_rd, wb_data);
          mr1 = ins[19:15]; mr2 = ins[24:20]; mrd = ins[11:7];
          md  = d;
        end else mv = 0;
      end
      tick();
    end
    drive_idle();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 0;
    drive_idle();
    test_reset();
    test_addi();
    test_load_use();
    test_bypass();
    test_branch();
    test_backpressure_flush();
    test_illegal();
    test_async_reset();
    test_random(600);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 64-bit RISC-V pipeline; sits directly upstream of RegisterFile.
- Accepts fetched instructions over a valid/ready handshake, decodes the fields and drives RS1/RS2 to RegisterFile combinationally.
- Captures ReadData1/ReadData2 with writeback bypass, generates immediate and control, and holds the result in the ID/EX pipeline register.
- Detects load-use hazards and inserts bubbles; supports flush from branch resolution.

Parameters:
- XLEN, 64, datapath width.
- CNT_W, 32, width of the saturating stall counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- in_valid  in  1  fetch holds a valid instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc  in  XLEN  instruction PC
- in_instr  in  32  instruction word
- rs1_addr  out  5  in_instr[19:15], to RegisterFile RS1
- rs2_addr  out  5  in_instr[24:20], to RegisterFile RS2
- rf_rdata1  in  XLEN  RegisterFile ReadData1
- rf_rdata2  in  XLEN  RegisterFile ReadData2
- wb_reg_write  in  1  writeback writes this cycle
- wb_rd  in  5  writeback destination
- wb_data  in  XLEN  writeback value
- flush  in  1  kill the ID/EX contents and the incoming instruction
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  EX consumes this cycle
- out_pc, out_rs1_val, out_rs2_val, out_imm  out  XLEN  ID/EX payload
- out_rs1, out_rs2, out_rd  out  5  register indices
- out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_branch, out_alu_src, out_illegal  out  1  control
- out_alu_op  out  2  00 ld/st add, 01 branch sub, 10 funct-decoded
- stall_count  out  CNT_W  load-use stall cycles, saturating

Behaviour:
- Reset (reset==0, async): every output register and stall_count clear to 0; out_valid=0.
- Decode by opcode:
  - 0110011 R: reg_write=1, alu_op=10.
  - 0010011 I-ALU: reg_write=1, alu_src=1, alu_op=10.
  - 0000011 load: reg_write=1, mem_read=1, mem_to_reg=1, alu_src=1, alu_op=00.
  - 0100011 store: mem_write=1, alu_src=1, alu_op=00.
  - 1100011 branch: branch=1, alu_op=01.
  - Any other opcode: all control 0, illegal=1, still passed through as valid.
- Immediate, sign-extended to XLEN:
  - I-type: instr[31:20].
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - R-type: 0.
- Operand value:
  - Index 0 gives 0.
  - Otherwise, if wb_reg_write and wb_rd==index, gives wb_data (same-cycle write bypass).
  - Otherwise gives rf_rdata.
- Load-use hazard:
  - Condition: hazard = out_valid & out_mem_read & out_rd!=0 & (out_rd==rs1_addr | (out_rd==rs2_addr & opcode uses rs2)), with in_valid high.
  - Opcodes that use rs2: R, store, branch.
- advance = !out_valid | out_ready.
- in_ready = advance & !hazard, or flush.
- Per-cycle priority:
  1. flush: out_valid<=0; the incoming instruction is accepted and dropped.
  2. advance & hazard: bubble (out_valid<=0, control cleared); stall_count increments, saturating at all-ones.
  3. advance & in_valid: capture the payload; out_valid<=1.
  4. advance & !in_valid: out_valid<=0.
  5. Otherwise: hold all outputs.
- A hazard while !advance does not count; the register simply holds.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction per cycle when out_ready stays high.
- Payload is stable while out_valid & !out_ready.
- Reset asserted mid-stall drops the instruction and clears the counter.

Decomposition:
- Package riscv_pkg:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH);
  - alu_op encodings;
  - packed ctrl_t struct (reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src, alu_op, illegal).
- Sub-module imm_gen: combinational instruction-to-immediate.

Test Plan:
- Reset, then addi x5,x0,7 (0x00700293): next cycle out_valid=1, out_imm=7, out_rd=5, reg_write=1, alu_src=1, alu_op=10.
- ld x1,8(x2) (0x00813083) then add x3,x1,x4 (0x004081B3):
  - add sees in_ready=0 for one cycle; a bubble is emitted; stall_count=1.
  - add emerges next with out_rs1=1.
- Same-cycle writeback: wb_reg_write=1, wb_rd=2, wb_data=0x1234, with rf_rdata1=0 and sd x3,16(x2) (0x00313823): out_rs1_val=0x1234, out_imm=16, mem_write=1.
- beq x1,x2,-4 (0xFE208EE3): out_imm=0xFFFF_FFFF_FFFF_FFFC, branch=1, alu_op=01.
- out_ready=0 for 3 cycles with out_valid=1: payload held, in_ready=0. flush then gives out_valid=0 next cycle, with the incoming instruction dropped.
- Opcode 0x7F: out_illegal=1, all other control 0. Reset pulsed low asynchronously mid-cycle: out_valid drops immediately.
